// File: rtl/reg_bank_arbiter.sv
// Purpose : round-robin front end that lets NUM_HOSTS request/ack channels share one register bank.
//           Each grant is one bank access with an address range check and a response timeout.
// Latency : request seen in IDLE cycle T -> bank_valid in T+1 -> host_ack in T+2 with a same-cycle bank ack
//           (range error: host_ack in T+1).
// Backpr. : hosts hold req/fields until their one-cycle ack; ena=0 blocks new grants only;
//           bank stalls are bounded by TIMEOUT_CYC.
// Ports   : clk/rst (async, active-high); ena; host_* request channels (packed per host);
//           host_ack/host_err/host_rdata responses; grant_id/busy status; bank_* access channel.
module reg_bank_arbiter #(
    parameter int NUM_HOSTS   = 2,
    parameter int REG_W       = 8,
    parameter int ADDR_W      = 8,
    parameter int BANK_ADDR_W = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [NUM_HOSTS-1:0]           host_req,
    input  logic [NUM_HOSTS-1:0]           host_wr_rdn,
    input  logic [NUM_HOSTS*ADDR_W-1:0]    host_addr,
    input  logic [NUM_HOSTS*REG_W-1:0]     host_wdata,
    output logic [NUM_HOSTS-1:0]           host_ack,
    output logic [NUM_HOSTS-1:0]           host_err,
    output logic [REG_W-1:0]               host_rdata,
    output logic [$clog2(NUM_HOSTS)-1:0]   grant_id,
    output logic                           busy,
    output logic                           bank_valid,
    output logic                           bank_wr_rdn,
    output logic [BANK_ADDR_W-1:0]         bank_addr,
    output logic [REG_W-1:0]               bank_wdata,
    input  logic [REG_W-1:0]               bank_rdata,
    input  logic                           bank_ack,
    input  logic                           bank_err
);

    localparam int GW = $clog2(NUM_HOSTS);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;     // last granted host; search starts just past it
    logic [CW-1:0]   tmo_cnt;

    // Round-robin pick: first requester at rr_ptr+1, rr_ptr+2, ... with wrap.
    logic            gnt_found;
    logic [GW-1:0]   gnt_idx;
    logic [GW-1:0]   cand;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_HOSTS; k++) begin
            cand = GW'((int'(rr_ptr) + k) % NUM_HOSTS);
            if (!gnt_found && host_req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Fields of the candidate host, muxed out of the packed request buses.
    logic [ADDR_W-1:0] sel_addr;
    logic [REG_W-1:0]  sel_wdata;
    logic              sel_wr_rdn;
    logic              sel_out_of_range;

    always_comb begin
        sel_addr         = host_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_wdata        = host_wdata[int'(gnt_idx)*REG_W +: REG_W];
        sel_wr_rdn       = host_wr_rdn[gnt_idx];
        // Any set bit above the bank address field is outside the bank.
        sel_out_of_range = (sel_addr >> BANK_ADDR_W) != '0;
    end

    logic tmo_hit;
    always_comb begin
        tmo_hit = (TIMEOUT_CYC != 0) && (int'(tmo_cnt) == TIMEOUT_CYC - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= GW'(NUM_HOSTS - 1);
            tmo_cnt     <= '0;
            host_ack    <= '0;
            host_err    <= '0;
            host_rdata  <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            bank_valid  <= 1'b0;
            bank_wr_rdn <= 1'b0;
            bank_addr   <= '0;
            bank_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    host_ack <= '0;
                    host_err <= '0;
                    if (ena && gnt_found) begin
                        grant_id    <= gnt_idx;
                        rr_ptr      <= gnt_idx;
                        busy        <= 1'b1;
                        tmo_cnt     <= '0;
                        bank_wr_rdn <= sel_wr_rdn;
                        bank_addr   <= sel_addr[BANK_ADDR_W-1:0];
                        bank_wdata  <= sel_wdata;
                        if (sel_out_of_range) begin
                            // Bank is never touched; answer the host directly.
                            host_ack   <= NUM_HOSTS'(1) << gnt_idx;
                            host_err   <= NUM_HOSTS'(1) << gnt_idx;
                            host_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            bank_valid <= 1'b1;
                            state      <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (bank_ack || bank_err) begin
                        bank_valid <= 1'b0;
                        host_ack   <= NUM_HOSTS'(1) << grant_id;
                        host_err   <= bank_err ? (NUM_HOSTS'(1) << grant_id) : '0;
                        // Error wins over ack, and writes return no data.
                        host_rdata <= (!bank_wr_rdn && !bank_err) ? bank_rdata : '0;
                        state      <= RESP;
                    end else if (tmo_hit) begin
                        bank_valid <= 1'b0;
                        host_ack   <= NUM_HOSTS'(1) << grant_id;
                        host_err   <= NUM_HOSTS'(1) << grant_id;
                        host_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    // host_rdata is left alone so it holds until the next response.
                    host_ack <= '0;
                    host_err <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    bank_valid <= 1'b0;
                    host_ack   <= '0;
                    host_err   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a response scoreboard and a simple bank model.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [1:0]  host_req;
    logic [1:0]  host_wr_rdn;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic [1:0]  host_ack;
    logic [1:0]  host_err;
    logic [7:0]  host_rdata;
    logic [0:0]  grant_id;
    logic        busy;
    logic        bank_valid;
    logic        bank_wr_rdn;
    logic [3:0]  bank_addr;
    logic [7:0]  bank_wdata;
    logic [7:0]  bank_rdata;
    logic        bank_ack;
    logic        bank_err;

    always #5 clk = ~clk;

    reg_bank_arbiter #(
        .NUM_HOSTS(2), .REG_W(8), .ADDR_W(8), .BANK_ADDR_W(4), .TIMEOUT_CYC(15)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .host_req(host_req), .host_wr_rdn(host_wr_rdn),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .grant_id(grant_id), .busy(busy),
        .bank_valid(bank_valid), .bank_wr_rdn(bank_wr_rdn),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .bank_ack(bank_ack), .bank_err(bank_err)
    );

    // Bank model: responds in the same cycle it sees bank_valid when enabled.
    logic       ack_en, err_en, ovr_en;
    logic [7:0] ovr_val;
    assign bank_ack   = bank_valid & ack_en;
    assign bank_err   = bank_valid & err_en;
    assign bank_rdata = ovr_en ? ovr_val : {bank_addr, ~bank_addr};

    function automatic logic [7:0] bank_model(input logic [3:0] a);
        return {a, ~a};
    endfunction

    typedef struct {
        int         host;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   valid_cycles = 0;
    int   wr_cycles = 0;

    // Response monitor: every host_ack must match the oldest expected response.
    always @(negedge clk) begin
        if (bank_valid) valid_cycles++;
        if (bank_valid && bank_wr_rdn) wr_cycles++;
        if (host_ack != 2'b00) begin
            `CHK("ack_onehot", $countones(host_ack), 1)
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_ack observed=%0h expected=none", host_ack);
            end else begin
                e = sb.pop_front();
                `CHK("ack_host", host_ack, 2'(1 << e.host))
                `CHK("ack_err", host_err, (e.err ? 2'(1 << e.host) : 2'b00))
                `CHK("ack_rdata", host_rdata, e.rdata)
            end
        end else begin
            `CHK("idle_err", host_err, 2'b00)
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int v0;
        int w0;

        rst = 1'b1; ena = 1'b1;
        host_req = '0; host_wr_rdn = '0; host_addr = '0; host_wdata = '0;
        ack_en = 1'b1; err_en = 1'b0; ovr_en = 1'b0; ovr_val = '0;
        repeat (2) @(posedge clk);
        #1;
        `CHK("rst_ack", host_ack, 2'b00)
        `CHK("rst_rdata", host_rdata, 8'h00)
        `CHK("rst_grant", grant_id, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_valid", bank_valid, 1'b0)
        `CHK("rst_bank_fields", {bank_wr_rdn, bank_addr, bank_wdata}, 13'h0)
        rst = 1'b0;
        tick();

        // Single read, same-cycle bank ack.
        ovr_en = 1'b1; ovr_val = 8'hA5;
        host_addr[7:0] = 8'h03; host_wr_rdn[0] = 1'b0; host_req[0] = 1'b1;
        sb.push_back('{0, 1'b0, 8'hA5});
        tick();
        `CHK("rd_valid_t1", bank_valid, 1'b1)
        `CHK("rd_addr", bank_addr, 4'h3)
        `CHK("rd_grant", grant_id, 1'b0)
        `CHK("rd_busy", busy, 1'b1)
        tick();
        `CHK("rd_ack_t2", host_ack, 2'b01)
        host_req = '0;
        tick(); tick();
        `CHK("rd_rdata_hold", host_rdata, 8'hA5)

        // Contention from a fresh reset: grants alternate starting at host 0.
        rst = 1'b1; #1; rst = 1'b0;
        ovr_en = 1'b0;
        host_addr = {8'h07, 8'h02}; host_wr_rdn = 2'b00;
        sb.push_back('{0, 1'b0, bank_model(4'h2)});
        sb.push_back('{1, 1'b0, bank_model(4'h7)});
        sb.push_back('{0, 1'b0, bank_model(4'h2)});
        sb.push_back('{1, 1'b0, bank_model(4'h7)});
        host_req = 2'b11;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            tick();
            if (host_ack != 2'b00) n++;
        end
        host_req = '0;
        `CHK("contention_acks", n, 4)
        tick(); tick();

        // Out-of-range write from host 1: no bank access, immediate error.
        v0 = valid_cycles; w0 = wr_cycles;
        host_addr[15:8] = 8'h10; host_wr_rdn = 2'b10; host_wdata[15:8] = 8'h3C;
        host_req = 2'b10;
        sb.push_back('{1, 1'b1, 8'h00});
        tick();
        `CHK("oor_ack_t1", host_ack, 2'b10)
        `CHK("oor_valid", bank_valid, 1'b0)
        host_req = '0; host_wr_rdn = '0;
        tick(); tick();
        `CHK("oor_valid_cycles", valid_cycles, v0)
        `CHK("oor_writes", wr_cycles, w0)

        // Timeout: bank never answers.
        ack_en = 1'b0;
        host_addr[7:0] = 8'h05; host_req = 2'b01;
        sb.push_back('{0, 1'b1, 8'h00});
        tick();
        cnt = 0;
        for (int c = 0; c < 40 && bank_valid; c++) begin
            cnt++;
            tick();
        end
        `CHK("tmo_valid_len", cnt, 15)
        `CHK("tmo_ack", host_ack, 2'b01)
        host_req = '0; ack_en = 1'b1;
        tick(); tick();

        // bank_err together with bank_ack on a read: error wins, data zeroed.
        err_en = 1'b1; ovr_en = 1'b1; ovr_val = 8'h5A;
        host_addr[7:0] = 8'h06; host_req = 2'b01;
        sb.push_back('{0, 1'b1, 8'h00});
        tick();
        `CHK("err_valid", bank_valid, 1'b1)
        tick();
        `CHK("err_ack", host_ack, 2'b01)
        `CHK("err_rdata", host_rdata, 8'h00)
        host_req = '0; err_en = 1'b0; ovr_en = 1'b0;
        tick(); tick();

        // ena low blocks grants; raising it grants on the next edge.
        ena = 1'b0; ack_en = 1'b0;
        host_addr[7:0] = 8'h04; host_req = 2'b01;
        repeat (3) tick();
        `CHK("ena0_valid", bank_valid, 1'b0)
        `CHK("ena0_busy", busy, 1'b0)
        ena = 1'b1;
        tick();
        `CHK("ena1_valid", bank_valid, 1'b1)
        `CHK("ena1_grant", grant_id, 1'b0)
        tick();

        // Reset in BUSY aborts silently and restores host 0 priority.
        rst = 1'b1;
        #1;
        `CHK("rst_busy_valid", bank_valid, 1'b0)
        `CHK("rst_busy_busy", busy, 1'b0)
        `CHK("rst_busy_ack", host_ack, 2'b00)
        host_req = '0; ack_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        host_addr = {8'h07, 8'h02}; host_req = 2'b11;
        sb.push_back('{0, 1'b0, bank_model(4'h2)});
        tick();
        `CHK("post_rst_grant", grant_id, 1'b0)
        `CHK("post_rst_valid", bank_valid, 1'b1)
        tick();
        `CHK("post_rst_ack", host_ack, 2'b01)
        host_req = '0;
        repeat (3) tick();
        `CHK("sb_empty", sb.size(), 0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
